// File: rtl/alu_seq.sv
// Clocked ALU with a start/done handshake. Add, subtract and pass finish in one cycle;
// multiply (shift-add) and divide (restoring) iterate one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             dz
);

    // state | meaning
    // IDLE  | waiting for start; single-cycle ops and divide-by-zero resolve here
    // RUN   | WIDTH iterations of shift-add multiply or restoring divide
    // DONE  | result registered, done pulses for this one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]     op_a, op_a_nxt;
    logic [WIDTH-1:0]     op_b, op_b_nxt;
    logic [2:0]           op_code, op_code_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH:0]       rem, rem_nxt;
    logic                 load;
    logic [WIDTH-1:0]     res;
    logic                 div0;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH+1:0]     div_shift;
    logic                 div_ge;
    logic [WIDTH:0]       div_rem;
    logic [WIDTH-1:0]     div_q;

    // acc holds {partial product, remaining multiplier} for multiply, and the
    // shifting dividend/quotient in its low half for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
        mul_acc   = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = (div_shift >= {2'b00, op_b});
        div_rem   = div_ge ? (div_shift[WIDTH:0] - {1'b0, op_b}) : div_shift[WIDTH:0];
        div_q     = {acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_a_nxt    = op_a;
        op_b_nxt    = op_b;
        op_code_nxt = op_code;
        acc_nxt     = acc;
        rem_nxt     = rem;
        load        = 1'b0;
        res         = '0;
        div0        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_a_nxt    = in1;
                    op_b_nxt    = in2;
                    op_code_nxt = alu_op;
                    case (alu_op)
                        3'd1: begin
                            res       = in2 - in1;
                            load      = 1'b1;
                            state_nxt = DONE;
                        end
                        3'd2: begin
                            acc_nxt   = {{WIDTH{1'b0}}, in2};
                            cnt_nxt   = '0;
                            state_nxt = RUN;
                        end
                        3'd3: begin
                            if (in2 == '0) begin
                                res       = '1;
                                div0      = 1'b1;
                                load      = 1'b1;
                                state_nxt = DONE;
                            end else begin
                                acc_nxt   = {{WIDTH{1'b0}}, in1};
                                rem_nxt   = '0;
                                cnt_nxt   = '0;
                                state_nxt = RUN;
                            end
                        end
                        3'd4: begin
                            res       = in2;
                            load      = 1'b1;
                            state_nxt = DONE;
                        end
                        default: begin
                            res       = in1 + in2;
                            load      = 1'b1;
                            state_nxt = DONE;
                        end
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (op_code == 3'd2) begin
                    acc_nxt = mul_acc;
                end else begin
                    acc_nxt = {acc[2*WIDTH-1:WIDTH], div_q};
                    rem_nxt = div_rem;
                end
                if (cnt == LAST) begin
                    res       = (op_code == 3'd2) ? mul_acc[WIDTH-1:0] : div_q;
                    load      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            acc     <= '0;
            rem     <= '0;
            alu_out <= '0;
            z       <= 1'b0;
            dz      <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_a    <= op_a_nxt;
            op_b    <= op_b_nxt;
            op_code <= op_code_nxt;
            acc     <= acc_nxt;
            rem     <= rem_nxt;
            if (load) begin
                alu_out <= res;
                z       <= (res == '0);
                dz      <= div0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 16-bit and an 8-bit instance, each with its own
// expectation queue drained by a monitor whenever done is seen.
module tb_alu_seq;

    typedef struct {
        logic [15:0] out;
        logic        z;
        logic        dz;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    logic        a_start = 1'b0;
    logic [15:0] a_in1 = '0, a_in2 = '0;
    logic [2:0]  a_op = '0;
    logic        a_busy, a_done, a_z, a_dz;
    logic [15:0] a_out;

    logic        b_start = 1'b0;
    logic [7:0]  b_in1 = '0, b_in2 = '0;
    logic [2:0]  b_op = '0;
    logic        b_busy, b_done, b_z, b_dz;
    logic [7:0]  b_out;

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(a_start), .in1(a_in1), .in2(a_in2), .alu_op(a_op),
        .busy(a_busy), .done(a_done), .alu_out(a_out), .z(a_z), .dz(a_dz)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(b_start), .in1(b_in1), .in2(b_in2), .alu_op(b_op),
        .busy(b_busy), .done(b_done), .alu_out(b_out), .z(b_z), .dz(b_dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            if (q16.size() == 0) begin
                chk("done16_without_start", 32'(a_done), 32'd0);
            end else begin
                e16 = q16.pop_front();
                chk("out16", 32'(a_out), 32'(e16.out));
                chk("z16", 32'(a_z), 32'(e16.z));
                chk("dz16", 32'(a_dz), 32'(e16.dz));
                chk("latency16", 32'(cyc), 32'(e16.due));
            end
        end
    end

    always @(negedge clk) begin
        if (b_done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("done8_without_start", 32'(b_done), 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("out8", 32'(b_out), 32'(e8.out));
                chk("z8", 32'(b_z), 32'(e8.z));
                chk("dz8", 32'(b_dz), 32'(e8.dz));
                chk("latency8", 32'(cyc), 32'(e8.due));
            end
        end
    end

    // Expected latency is counted in the bench's cycle counter: issued at the
    // negedge with cyc=c, done must be seen at the negedge with cyc=c+lat.
    task automatic issue16(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] ex, input logic ez, input logic edz, input int lat);
        @(negedge clk);
        a_op = op; a_in1 = x; a_in2 = y; a_start = 1'b1;
        q16.push_back('{ex, ez, edz, cyc + lat});
        @(posedge clk);
        #1 a_start = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] ex, input logic ez, input logic edz, input int lat);
        @(negedge clk);
        b_op = op; b_in1 = x; b_in2 = y; b_start = 1'b1;
        q8.push_back('{{8'h00, ex}, ez, edz, cyc + lat});
        @(posedge clk);
        #1 b_start = 1'b0;
    endtask

    task automatic wait_all();
        int i = 0;
        while ((q16.size() != 0 || q8.size() != 0) && i < 60) begin
            @(posedge clk);
            #2;
            i++;
        end
        if (q16.size() != 0 || q8.size() != 0) begin
            chk("done_timeout_pending", 32'(q16.size() + q8.size()), 32'd0);
            q16.delete();
            q8.delete();
        end
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] x,
                                        input logic [7:0] y, output logic dzo);
        logic [15:0] p;
        dzo = 1'b0;
        case (op)
            3'd1: p = {8'h00, 8'(y - x)};
            3'd2: p = 16'(x) * 16'(y);
            3'd3: begin
                if (y == 8'h00) begin
                    p = 16'h00FF;
                    dzo = 1'b1;
                end else begin
                    p = 16'(x / y);
                end
            end
            3'd4: p = {8'h00, y};
            default: p = 16'(x) + 16'(y);
        endcase
        return p[7:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [7:0] x, y, ex;
        logic       edz;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(a_busy), 32'd0);
        chk("reset_done", 32'(a_done), 32'd0);
        chk("reset_out", 32'(a_out), 32'd0);
        chk("reset_z", 32'(a_z), 32'd0);
        chk("reset_dz", 32'(a_dz), 32'd0);
        chk("reset_busy8", 32'(b_busy), 32'd0);

        issue16(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1);  wait_all();
        issue16(3'd1, 16'd5, 16'd3, 16'hFFFE, 1'b0, 1'b0, 1);        wait_all();
        issue16(3'd4, 16'hBEEF, 16'h1234, 16'h1234, 1'b0, 1'b0, 1);  wait_all();
        issue16(3'd5, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1);  wait_all();
        issue16(3'd6, 16'd7, 16'd8, 16'd15, 1'b0, 1'b0, 1);          wait_all();
        issue16(3'd7, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1);  wait_all();

        // Multiply with busy tracking, ignored start pulses and operand churn during RUN.
        issue16(3'd2, 16'd300, 16'd300, 16'h5F90, 1'b0, 1'b0, 17);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("mul_busy", 32'(a_busy), 32'd1);
            if (k == 3 || k == 7) begin
                a_start = 1'b1; a_op = 3'd0; a_in1 = 16'h0001; a_in2 = 16'h0001;
            end else begin
                a_start = 1'b0;
            end
            if (k == 5) begin
                a_in1 = 16'hAAAA; a_in2 = 16'h5555; a_op = 3'd4;
            end
        end
        @(negedge clk);
        chk("mul_busy_after", 32'(a_busy), 32'd0);
        wait_all();

        issue16(3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17); wait_all();
        issue16(3'd3, 16'd1000, 16'd7, 16'd142, 1'b0, 1'b0, 17);     wait_all();
        issue16(3'd3, 16'hFFFF, 16'd1, 16'hFFFF, 1'b0, 1'b0, 17);    wait_all();
        issue16(3'd3, 16'd5, 16'd9, 16'h0000, 1'b1, 1'b0, 17);       wait_all();
        issue16(3'd3, 16'h1234, 16'd0, 16'hFFFF, 1'b0, 1'b1, 1);     wait_all();

        // Reset in the fifth cycle of a multiply: aborted, no done for it.
        issue16(3'd2, 16'd300, 16'd300, 16'h5F90, 1'b0, 1'b0, 17);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        q16.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_out", 32'(a_out), 32'd0);
        chk("abort_dz", 32'(a_dz), 32'd0);
        repeat (20) @(negedge clk);
        issue16(3'd0, 16'd2, 16'd3, 16'd5, 1'b0, 1'b0, 1);           wait_all();

        // start held high: first op accepted, start in DONE ignored, next accepted in IDLE.
        @(negedge clk);
        a_op = 3'd0; a_in1 = 16'd1; a_in2 = 16'd1; a_start = 1'b1;
        q16.push_back('{16'd2, 1'b0, 1'b0, cyc + 1});
        q16.push_back('{16'd4, 1'b0, 1'b0, cyc + 3});
        @(posedge clk);
        #1 a_in1 = 16'd2; a_in2 = 16'd2;
        @(posedge clk);
        @(posedge clk);
        #1 a_start = 1'b0;
        wait_all();

        issue8(3'd2, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 9);            wait_all();
        issue8(3'd3, 8'd200, 8'd3, 8'd66, 1'b0, 1'b0, 9);            wait_all();
        issue8(3'd1, 8'd3, 8'd5, 8'd2, 1'b0, 1'b0, 1);               wait_all();
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(7, 0));
            x  = 8'($urandom_range(255, 0));
            y  = 8'($urandom_range(255, 0));
            if (i == 5) begin
                op = 3'd3;
                y  = 8'h00;
            end
            ex = ref8(op, x, y, edz);
            issue8(op, x, y, ex, (ex == 8'h00), edz,
                   (op == 3'd2 || (op == 3'd3 && y != 8'h00)) ? 9 : 1);
            wait_all();
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
